// File: rtl/pe_instr_sequencer.sv
// Per-PE instruction sequencer: decodes against MY_ID, issues the command for rpt+1 cycles (1-cycle latency),
// and forwards qualifying instructions through a one-entry slot; stall or a full, undrained slot blocks acceptance.
module pe_instr_sequencer #(
    parameter int MY_ID       = 0,
    parameter int LOGB        = 3,
    parameter int OP_WIDTH    = 3,
    parameter int RPT_WIDTH   = 4,
    parameter int INSTR_WIDTH = 1 + RPT_WIDTH + LOGB + OP_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic                   cmd_stall,
    output logic [OP_WIDTH-1:0]    command,
    output logic                   cmd_valid,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_out_valid,
    input  logic                   instr_out_ready,
    output logic                   err_illegal
);

    localparam logic [OP_WIDTH-1:0] OP_IDLE    = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_COMPUTE = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_FORWARD = OP_WIDTH'(4);
    localparam logic [LOGB-1:0]     BID        = {LOGB{1'b1}};
    localparam logic [LOGB-1:0]     MY_ID_L    = LOGB'(MY_ID);

    typedef enum logic {S_WAIT, S_ISSUE} state_t;

    state_t                 r_state, w_state_nxt;
    logic [OP_WIDTH-1:0]    r_command, w_command_nxt;
    logic                   r_cmd_valid, w_cmd_valid_nxt;
    logic [RPT_WIDTH-1:0]   r_remain, w_remain_nxt;
    logic [INSTR_WIDTH-1:0] r_instr_out;
    logic                   r_instr_out_valid;
    logic                   r_err_illegal;

    logic [OP_WIDTH-1:0]    w_op;
    logic [LOGB-1:0]        w_id;
    logic [RPT_WIDTH-1:0]   w_rpt;
    logic                   w_fwd;
    logic [OP_WIDTH-1:0]    w_resolved;
    logic [OP_WIDTH-1:0]    w_cmd;
    logic                   w_illegal;
    logic                   w_accept;
    logic                   w_fwd_cond;

    assign w_op  = instr_in[OP_WIDTH-1:0];
    assign w_id  = instr_in[OP_WIDTH +: LOGB];
    assign w_rpt = instr_in[OP_WIDTH+LOGB +: RPT_WIDTH];
    assign w_fwd = instr_in[INSTR_WIDTH-1];

    always_comb begin
        w_resolved = OP_IDLE;
        if (w_id == BID || w_id == MY_ID_L) begin
            w_resolved = w_op;
        end else if (MY_ID_L < w_id) begin
            w_resolved = (w_op == OP_COMPUTE) ? OP_COMPUTE : OP_FORWARD;
        end else begin
            w_resolved = (w_op == OP_COMPUTE) ? OP_COMPUTE : OP_IDLE;
        end
    end

    // Only a self- or broadcast-addressed opcode can resolve above FORWARD.
    assign w_illegal  = (w_resolved > OP_FORWARD);
    assign w_cmd      = w_illegal ? OP_IDLE : w_resolved;
    assign w_fwd_cond = w_fwd || (w_id == BID) || (MY_ID_L < w_id) || (w_op == OP_COMPUTE);

    assign instr_ready = rst_n && !cmd_stall && (r_remain == '0)
                         && (!r_instr_out_valid || instr_out_ready);
    assign w_accept    = instr_valid && instr_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_command_nxt   = r_command;
        w_cmd_valid_nxt = r_cmd_valid;
        w_remain_nxt    = r_remain;
        if (w_accept) begin
            w_state_nxt     = S_ISSUE;
            w_command_nxt   = w_cmd;
            w_cmd_valid_nxt = 1'b1;
            w_remain_nxt    = w_rpt;
        end else if (r_state == S_ISSUE && !cmd_stall) begin
            if (r_remain != '0) begin
                w_remain_nxt = r_remain - RPT_WIDTH'(1);
            end else begin
                w_state_nxt     = S_WAIT;
                w_command_nxt   = OP_IDLE;
                w_cmd_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_WAIT;
            r_command   <= OP_IDLE;
            r_cmd_valid <= 1'b0;
            r_remain    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_command   <= w_command_nxt;
            r_cmd_valid <= w_cmd_valid_nxt;
            r_remain    <= w_remain_nxt;
        end
    end

    // Forward slot ignores cmd_stall so downstream PEs keep moving.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr_out       <= '0;
            r_instr_out_valid <= 1'b0;
            r_err_illegal     <= 1'b0;
        end else begin
            if (w_accept && w_fwd_cond) begin
                r_instr_out       <= instr_in;
                r_instr_out_valid <= 1'b1;
            end else if (r_instr_out_valid && instr_out_ready) begin
                r_instr_out_valid <= 1'b0;
            end
            if (w_accept && w_illegal) begin
                r_err_illegal <= 1'b1;
            end
        end
    end

    assign command         = r_command;
    assign cmd_valid       = r_cmd_valid;
    assign instr_out       = r_instr_out;
    assign instr_out_valid = r_instr_out_valid;
    assign err_illegal     = r_err_illegal;

endmodule

// File: tb/tb_pe_instr_sequencer.sv
// Bench for pe_instr_sequencer (MY_ID=2): directed scenarios then random traffic,
// every cycle compared against a transaction-level model of the command burst and forward slot.
module tb_pe_instr_sequencer;

    logic        clk;
    logic        rst_n;
    logic [10:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic        cmd_stall;
    logic [2:0]  command;
    logic        cmd_valid;
    logic [10:0] instr_out;
    logic        instr_out_valid;
    logic        instr_out_ready;
    logic        err_illegal;

    pe_instr_sequencer #(.MY_ID(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instr_in        (instr_in),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .cmd_stall       (cmd_stall),
        .command         (command),
        .cmd_valid       (cmd_valid),
        .instr_out       (instr_out),
        .instr_out_valid (instr_out_valid),
        .instr_out_ready (instr_out_ready),
        .err_illegal     (err_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: number of command cycles still to be shown, the command, the slot content.
    int          m_left   = 0;
    logic [2:0]  m_cmd    = 3'd0;
    logic [10:0] m_slot   = 11'd0;
    bit          m_slot_v = 1'b0;
    bit          m_err    = 1'b0;
    bit          m_rst    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [10:0] mk(input bit fwd, input int rpt, input int id, input int op);
        mk = {fwd, 4'(rpt), 3'(id), 3'(op)};
    endfunction

    // Returns {illegal, cmd}.
    function automatic logic [3:0] ref_cmd(input int id, input int op);
        int c;
        if (id == 7 || id == 2) c = op;
        else if (id > 2)        c = (op == 3) ? 3 : 4;
        else                    c = (op == 3) ? 3 : 0;
        if (c > 4) ref_cmd = {1'b1, 3'd0};
        else       ref_cmd = {1'b0, 3'(c)};
    endfunction

    task automatic step(input bit rst, input bit vld, input logic [10:0] ins,
                        input bit stall, input bit ordy);
        bit         exp_rdy;
        bit         acc;
        bit         drain;
        logic [3:0] dec;
        int         id;
        int         op;
        rst_n           = rst;
        instr_valid     = vld;
        instr_in        = ins;
        cmd_stall       = stall;
        instr_out_ready = ordy;
        #1;
        exp_rdy = rst && !stall && (m_left <= 1) && (!m_slot_v || ordy);
        chk("instr_ready", 32'(instr_ready), 32'(exp_rdy));
        id = int'(ins[5:3]);
        op = int'(ins[2:0]);
        if (!rst) begin
            m_left = 0; m_cmd = 0; m_slot = 0; m_slot_v = 0; m_err = 0;
        end else begin
            acc   = vld && exp_rdy;
            drain = m_slot_v && ordy;
            if (acc) begin
                dec    = ref_cmd(id, op);
                m_left = int'(ins[9:6]) + 1;
                m_cmd  = dec[2:0];
                if (dec[3]) m_err = 1'b1;
            end else if (!stall && m_left > 0) begin
                m_left--;
            end
            if (acc && (ins[10] || id == 7 || id > 2 || op == 3)) begin
                m_slot   = ins;
                m_slot_v = 1'b1;
            end else if (drain) begin
                m_slot_v = 1'b0;
            end
        end
        m_rst = !rst;
        @(posedge clk);
        #1;
        chk("cmd_valid", 32'(cmd_valid), 32'(m_left > 0));
        chk("command", 32'(command), (m_left > 0) ? 32'(m_cmd) : 32'd0);
        chk("instr_out_valid", 32'(instr_out_valid), 32'(m_slot_v));
        chk("err_illegal", 32'(err_illegal), 32'(m_err));
        if (m_slot_v || m_rst) chk("instr_out", 32'(instr_out), 32'(m_slot));
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) step(1, 0, 11'd0, 0, ordy);
    endtask

    initial begin
        rst_n = 0; instr_valid = 0; instr_in = 0; cmd_stall = 0; instr_out_ready = 1;
        step(0, 0, 11'd0, 0, 1);
        step(0, 0, 11'd0, 0, 1);
        // Targeted READ0, 4 command cycles.
        step(1, 1, mk(0, 3, 2, 1), 0, 1);
        idle(5, 1);
        // Reset mid-burst with the slot full.
        step(1, 1, mk(1, 5, 2, 2), 0, 0);
        step(1, 0, 11'd0, 0, 0);
        step(0, 0, 11'd0, 0, 0);
        step(0, 0, 11'd0, 0, 0);
        idle(1, 1);
        // Upstream target, slot blocked by downstream.
        step(1, 1, mk(0, 0, 5, 2), 0, 0);
        step(1, 1, mk(0, 0, 2, 1), 0, 0);
        step(1, 1, mk(0, 0, 2, 1), 0, 0);
        step(1, 1, mk(0, 0, 2, 1), 0, 1);
        idle(2, 1);
        // Back-to-back COMPUTE to ids 0, 2, BID.
        step(1, 1, mk(0, 0, 0, 3), 0, 1);
        step(1, 1, mk(0, 0, 2, 3), 0, 1);
        step(1, 1, mk(0, 0, 7, 3), 0, 1);
        idle(2, 1);
        // Stall during a rpt=1 burst.
        step(1, 1, mk(0, 1, 2, 2), 0, 1);
        step(1, 1, mk(0, 0, 2, 1), 1, 1);
        step(1, 1, mk(0, 0, 2, 1), 1, 1);
        idle(3, 1);
        // Illegal opcodes.
        step(1, 1, mk(0, 0, 2, 6), 0, 1);
        step(1, 1, mk(0, 0, 1, 6), 0, 1);
        idle(2, 1);
        // Maximum repeat count.
        step(1, 1, mk(0, 15, 2, 3), 0, 1);
        idle(18, 1);
        for (int i = 0; i < 3000; i++) begin
            int  sel;
            int  id;
            int  rpt;
            sel = int'($urandom_range(3));
            id  = (sel == 0) ? 2 : (sel == 1) ? 7 : int'($urandom_range(7));
            rpt = ($urandom_range(9) == 0) ? 15 : int'($urandom_range(3));
            step($urandom_range(99) != 0,
                 $urandom_range(9) < 6,
                 mk(1'($urandom_range(1)), rpt, id, int'($urandom_range(7))),
                 $urandom_range(9) < 2,
                 $urandom_range(9) < 7);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
